// File: rtl/comparator_8bit.sv
// Registered magnitude comparator: one-hot lt/eq/gt flags one cycle after a valid operand pair.
// Optional build macro COMPARATOR_SIGNED_EN selects two's-complement operands (default: unsigned).
module comparator_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] inputP,
  input  logic [WIDTH-1:0] inputQ,
  output logic             out_valid,
  output logic             pLessThanQ,
  output logic             pEqualToQ,
  output logic             pGraterGreaterThanQ
);

  logic cmp_lt, cmp_eq, cmp_gt;
  logic valid_q, valid_d;
  logic lt_q, lt_d;
  logic eq_q, eq_d;
  logic gt_q, gt_d;

  // Cascade of 1-bit compare cells, MSB first; the first differing bit decides.
  always_comb begin
    logic eq_run, lt_run, gt_run;
    logic p_b, q_b, cell_gt, cell_lt;
    eq_run = 1'b1;
    lt_run = 1'b0;
    gt_run = 1'b0;
    p_b    = 1'b0;
    q_b    = 1'b0;
    cell_gt = 1'b0;
    cell_lt = 1'b0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      p_b     = inputP[WIDTH-1-k];
      q_b     = inputQ[WIDTH-1-k];
      cell_gt = p_b & ~q_b;
      cell_lt = ~p_b & q_b;
`ifdef COMPARATOR_SIGNED_EN
      // Sign stage: a set sign bit means the smaller operand.
      if (k == 0) begin
        cell_gt = ~p_b & q_b;
        cell_lt = p_b & ~q_b;
      end
`endif
      lt_run = lt_run | (eq_run & cell_lt);
      gt_run = gt_run | (eq_run & cell_gt);
      eq_run = eq_run & ~(cell_lt | cell_gt);
    end
    cmp_lt = lt_run;
    cmp_eq = eq_run;
    cmp_gt = gt_run;
  end

  // Flags hold their last result while no new operands arrive.
  always_comb begin
    valid_d = in_valid;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    if (in_valid) begin
      lt_d = cmp_lt;
      eq_d = cmp_eq;
      gt_d = cmp_gt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign out_valid           = valid_q;
  assign pLessThanQ          = lt_q;
  assign pEqualToQ           = eq_q;
  assign pGraterGreaterThanQ = gt_q;

endmodule

// File: tb/tb_comparator_8bit.sv
// Self-checking bench for comparator_8bit; expected flags come from an arithmetic reference model.
module tb_comparator_8bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] inputP;
  logic [7:0] inputQ;
  logic       out_valid;
  logic       pLessThanQ;
  logic       pEqualToQ;
  logic       pGraterGreaterThanQ;

  int checks   = 0;
  int failures = 0;

  // Reference model state: {valid, lt, eq, gt}
  logic [3:0] exp_out;
  logic       captured;

  comparator_8bit #(.WIDTH(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .inputP             (inputP),
    .inputQ             (inputQ),
    .out_valid          (out_valid),
    .pLessThanQ         (pLessThanQ),
    .pEqualToQ          (pEqualToQ),
    .pGraterGreaterThanQ(pGraterGreaterThanQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int value_of(input logic [7:0] x);
`ifdef COMPARATOR_SIGNED_EN
    return x[7] ? int'(x) - 256 : int'(x);
`else
    return int'(x);
`endif
  endfunction

  function automatic logic [3:0] observed();
    return {out_valid, pLessThanQ, pEqualToQ, pGraterGreaterThanQ};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={v,lt,eq,gt}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic v, input logic [7:0] p, input logic [7:0] q);
    int pv, qv;
    pv = value_of(p);
    qv = value_of(q);
    if (v) begin
      exp_out  = {1'b1, pv < qv, pv == qv, pv > qv};
      captured = 1'b1;
    end else begin
      exp_out[3] = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] p, input logic [7:0] q, input string tag);
    in_valid = v;
    inputP   = p;
    inputQ   = q;
    @(posedge clk);
    model_edge(v, p, q);
    #1;
    check(tag, observed(), exp_out);
  endtask

  initial begin
    int ones;
    exp_out  = '0;
    captured = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'($urandom);
    inputP   = 8'($urandom);
    inputQ   = 8'($urandom);
    #1;
    check("reset_async", observed(), 4'b0000);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom);
      inputP   = 8'($urandom);
      inputQ   = 8'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", observed(), 4'b0000);
    end
    rst_n = 1'b1;
    step(1'b0, 8'($urandom), 8'($urandom), "post_release_idle");
    check("post_release_const", observed(), 4'b0000);

    step(1'b1, 8'h00, 8'h00, "zero_eq");
    step(1'b1, 8'hFF, 8'hFF, "ones_eq");
    step(1'b1, 8'h40, 8'h80, "p40_q80");
    step(1'b1, 8'h07, 8'h02, "p07_q02");
    step(1'b1, 8'hFF, 8'h00, "pFF_q00");
`ifdef COMPARATOR_SIGNED_EN
    check("pFF_q00_signed_lt", observed(), 4'b1100);
`else
    check("pFF_q00_unsigned_gt", observed(), 4'b1001);
`endif

    step(1'b1, 8'h10, 8'h10, "b2b_eq");
    check("b2b_eq_const", observed(), 4'b1010);
    step(1'b1, 8'h0F, 8'h10, "b2b_lt");
    check("b2b_lt_const", observed(), 4'b1100);
    step(1'b1, 8'h11, 8'h10, "b2b_gt");
    check("b2b_gt_const", observed(), 4'b1001);
    step(1'b0, 8'($urandom), 8'($urandom), "idle_hold_gt");
    check("idle_hold_gt_const", observed(), 4'b0001);
    step(1'b0, 8'($urandom), 8'($urandom), "idle_hold_gt2");

    // Mid-stream reset between edges
    step(1'b1, 8'h01, 8'h02, "pre_reset");
    in_valid = 1'b1;
    inputP   = 8'h33;
    inputQ   = 8'h22;
    #2;
    rst_n = 1'b0;
    exp_out  = '0;
    captured = 1'b0;
    #1;
    check("midreset_immediate", observed(), 4'b0000);
    for (int i = 0; i < 2; i++) begin
      inputP = 8'($urandom);
      inputQ = 8'($urandom);
      @(posedge clk);
      #1;
      check("midreset_hold", observed(), 4'b0000);
    end
    #2;
    rst_n = 1'b1;
    step(1'b0, 8'h55, 8'h44, "no_stale_after_reset");

    for (int i = 0; i < 1000; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), 8'($urandom), "random");
      if (captured) begin
        ones = int'(pLessThanQ) + int'(pEqualToQ) + int'(pGraterGreaterThanQ);
        checks++;
        assert (ones == 1) else begin
          failures++;
          $error("FAIL onehot observed_ones=%0d expected_ones=1", ones);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
